game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 21 ++
 rtl/game_sequencer_if.sv | 28 ++
 rtl/game_sequencer_edge_detect.sv | 18 +
 rtl/game_sequencer.sv | 87 ++++++++
 tb/tb_game_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared game definitions: state encodings, score width and saturation limit.
// Used by the sequencer, the game datapath and the renderer.
package game_sequencer_pkg;

  localparam int SCORE_W       = 10;
  localparam int SCORE_MAX_DEF = 999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Increment that holds at the ceiling instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] max);
    return (s >= max) ? max : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Sequencer bus: frame/button/collision inputs and the physics/score outputs.
// master = game side driving events, slave = the sequencer.
interface game_sequencer_if;
  import game_sequencer_pkg::*;

  logic               frame_tick;
  logic               flap;
  logic               pause;
  logic               collide;
  logic               pipe_passed;
  game_state_e        state;
  logic               phys_init;
  logic               phys_step;
  logic               flap_cmd;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;

  modport master (
    output frame_tick, flap, pause, collide, pipe_passed,
    input  state, phys_init, phys_step, flap_cmd, score, high_score
  );

  modport slave (
    input  frame_tick, flap, pause, collide, pipe_passed,
    output state, phys_init, phys_step, flap_cmd, score, high_score
  );

endinterface

// File: rtl/game_sequencer_edge_detect.sv
// Rising-edge detector for an already-synchronized level button.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM: IDLE -> PLAY <-> PAUSE, PLAY -> OVER -> IDLE after a frame lockout.
// Drives physics init/step pulses and tracks score / high score.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int LOCKOUT_FRAMES = 50,
  parameter int SCORE_MAX      = SCORE_MAX_DEF
) (
  input  logic             clock,
  input  logic             reset,
  game_sequencer_if.slave  bus
);

  localparam int LOCK_W = $clog2(LOCKOUT_FRAMES + 2);

  logic               flap_rise, pause_rise;
  game_state_e        state;
  logic               phys_init, phys_step, flap_cmd, pending_flap;
  logic [SCORE_W-1:0] score, high_score;
  logic [LOCK_W-1:0]  lockout;

  edge_detect u_flap_edge  (.clock(clock), .reset(reset), .din(bus.flap),  .rise(flap_rise));
  edge_detect u_pause_edge (.clock(clock), .reset(reset), .din(bus.pause), .rise(pause_rise));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      phys_init    <= 1'b0;
      phys_step    <= 1'b0;
      flap_cmd     <= 1'b0;
      pending_flap <= 1'b0;
      score        <= '0;
      high_score   <= '0;
      lockout      <= '0;
    end else begin
      phys_init <= 1'b0;
      phys_step <= 1'b0;
      flap_cmd  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flap_rise) begin
            state     <= ST_PLAY;
            phys_init <= 1'b1;
            score     <= '0;
          end
        end
        ST_PLAY: begin
          // Collision beats pause; pause freezes the frame it arrives on.
          if (bus.frame_tick && bus.collide) begin
            state        <= ST_OVER;
            lockout      <= LOCK_W'(LOCKOUT_FRAMES);
            pending_flap <= 1'b0;
            if (score > high_score) high_score <= score;
          end else if (pause_rise) begin
            state        <= ST_PAUSE;
            pending_flap <= 1'b0;
          end else if (bus.frame_tick) begin
            phys_step    <= 1'b1;
            flap_cmd     <= pending_flap | flap_rise;
            pending_flap <= 1'b0;
            if (bus.pipe_passed) score <= sat_inc(score, SCORE_W'(SCORE_MAX));
          end else if (flap_rise) begin
            pending_flap <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (pause_rise) state <= ST_PLAY;
        end
        ST_OVER: begin
          if (lockout == '0) begin
            if (flap_rise) state <= ST_IDLE;
          end else if (bus.frame_tick) begin
            lockout <= lockout - LOCK_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.phys_init  = phys_init;
  assign bus.phys_step  = phys_step;
  assign bus.flap_cmd   = flap_cmd;
  assign bus.score      = score;
  assign bus.high_score = high_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected output events,
// a negedge monitor compares each state change / physics pulse against the queue.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  typedef struct packed {
    logic [1:0] st;
    logic       init;
    logic       step;
    logic       fc;
    logic [9:0] sc;
    logic [9:0] hi;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];
  ev_t  mon_act, mon_exp;
  logic [1:0] prev_st = 2'd0;

  game_sequencer_if bus ();

  game_sequencer #(.LOCKOUT_FRAMES(50), .SCORE_MAX(999)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Monitor: any state change or physics pulse is an output event.
  always @(negedge clock) begin
    if (!reset && (bus.phys_init || bus.phys_step || 2'(bus.state) != prev_st)) begin
      mon_act = {2'(bus.state), bus.phys_init, bus.phys_step, bus.flap_cmd,
                 bus.score, bus.high_score};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got st=%0d init=%0d step=%0d fc=%0d sc=%0d hi=%0d, none expected",
                 mon_act.st, mon_act.init, mon_act.step, mon_act.fc, mon_act.sc, mon_act.hi);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL event @%0t: got st=%0d init=%0d step=%0d fc=%0d sc=%0d hi=%0d, expected st=%0d init=%0d step=%0d fc=%0d sc=%0d hi=%0d",
                   $time, mon_act.st, mon_act.init, mon_act.step, mon_act.fc, mon_act.sc, mon_act.hi,
                   mon_exp.st, mon_exp.init, mon_exp.step, mon_exp.fc, mon_exp.sc, mon_exp.hi);
        end
      end
    end
    prev_st = 2'(bus.state);
  end

  task automatic expect_ev(input int st, input bit init, input bit step, input bit fc,
                           input int sc, input int hi);
    ev_t e;
    e.st = 2'(st); e.init = init; e.step = step; e.fc = fc;
    e.sc = 10'(sc); e.hi = 10'(hi);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic press_flap();
    bus.flap = 1'b1; idle(1);
    bus.flap = 1'b0; idle(1);
  endtask

  task automatic press_pause();
    bus.pause = 1'b1; idle(1);
    bus.pause = 1'b0; idle(1);
  endtask

  task automatic tick(input bit pp, input bit col, input bit pse);
    bus.frame_tick = 1'b1; bus.pipe_passed = pp; bus.collide = col; bus.pause = pse;
    idle(1);
    bus.frame_tick = 1'b0; bus.pipe_passed = 1'b0; bus.collide = 1'b0; bus.pause = 1'b0;
    idle(1);
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.flap = 1'b0; bus.pause = 1'b0;
    bus.collide = 1'b0; bus.pipe_passed = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    chk("reset_state", int'(bus.state), 0);
    chk("reset_score", int'(bus.score), 0);
    chk("reset_high",  int'(bus.high_score), 0);
    chk("reset_pulses", int'({bus.phys_init, bus.phys_step, bus.flap_cmd}), 0);

    // Start game: phys_init with the IDLE->PLAY transition
    expect_ev(1, 1, 0, 0, 0, 0);
    press_flap();

    // Off-tick collide/pipe must be ignored
    bus.collide = 1'b1; bus.pipe_passed = 1'b1; idle(1);
    bus.collide = 1'b0; bus.pipe_passed = 1'b0; idle(1);

    // Three scoring frames
    for (int i = 1; i <= 3; i++) begin
      expect_ev(1, 0, 1, 0, i, 0);
      tick(1, 0, 0);
    end

    // Flap 5 cycles before tick is carried into the next step only
    press_flap();
    idle(3);
    expect_ev(1, 0, 1, 1, 3, 0);
    tick(0, 0, 0);
    expect_ev(1, 0, 1, 0, 3, 0);
    tick(0, 0, 0);

    // Reach score 4 then crash: high score captures 4
    expect_ev(1, 0, 1, 0, 4, 0);
    tick(1, 0, 0);
    expect_ev(3, 0, 0, 0, 4, 4);
    tick(1, 1, 0);

    // Lockout: flap after 10 ticks ignored; after 50 accepted
    repeat (10) tick(0, 0, 0);
    press_flap();
    chk("over_lockout_hold", int'(bus.state), 3);
    press_pause();
    chk("over_pause_ignored", int'(bus.state), 3);
    repeat (40) tick(0, 0, 0);
    expect_ev(0, 0, 0, 0, 4, 4);
    press_flap();

    // New game up to score 7
    expect_ev(1, 1, 0, 0, 0, 4);
    press_flap();
    for (int i = 1; i <= 7; i++) begin
      expect_ev(1, 0, 1, 0, i, 4);
      tick(1, 0, 0);
    end

    // Pause freezes score and ignores flap/ticks
    expect_ev(2, 0, 0, 0, 7, 4);
    press_pause();
    tick(1, 0, 0);
    press_flap();
    tick(1, 0, 0);
    chk("pause_score_frozen", int'(bus.score), 7);
    expect_ev(1, 0, 0, 0, 7, 4);
    press_pause();

    // Collide + pipe + pause edge on one tick: OVER wins, no increment
    expect_ev(3, 0, 0, 0, 7, 7);
    tick(1, 1, 1);
    chk("crash_score", int'(bus.score), 7);
    chk("crash_high",  int'(bus.high_score), 7);

    repeat (50) tick(0, 0, 0);
    expect_ev(0, 0, 0, 0, 7, 7);
    press_flap();
    expect_ev(1, 1, 0, 0, 0, 7);
    press_flap();

    // Saturation at 999
    for (int i = 1; i <= 999; i++) begin
      expect_ev(1, 0, 1, 0, i, 7);
      tick(1, 0, 0);
    end
    expect_ev(1, 0, 1, 0, 999, 7);
    tick(1, 0, 0);
    chk("score_saturated", int'(bus.score), 999);
    expect_ev(3, 0, 0, 0, 999, 999);
    tick(0, 1, 0);

    // Reset mid-lockout clears everything next cycle
    repeat (5) tick(0, 0, 0);
    expect_ev(0, 0, 0, 0, 0, 0);
    reset = 1'b1; bus.frame_tick = 1'b1; bus.flap = 1'b1;
    idle(1);
    reset = 1'b0; bus.frame_tick = 1'b0; bus.flap = 1'b0;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_high",  int'(bus.high_score), 0);
    chk("rst_pulses", int'({bus.phys_init, bus.phys_step, bus.flap_cmd}), 0);
    idle(1);

    // Game restarts cleanly after reset
    expect_ev(1, 1, 0, 0, 0, 0);
    press_flap();

    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
